// File: rtl/noc_pkg.sv
// NoC link frame definitions shared by the transmit scheduler and its arbiter.
// Control frame = {1, code, 00, size}; data frame = {0, byte}.
package noc_pkg;

   typedef enum logic [2:0] {
      NOC_CODE_IDLE      = 3'b000,
      NOC_CODE_READ      = 3'b001,
      NOC_CODE_READ_RESP = 3'b010,
      NOC_CODE_WRITE     = 3'b011,
      NOC_CODE_WRITE_RESP= 3'b100,
      NOC_CODE_RSVD      = 3'b101,
      NOC_CODE_MSG       = 3'b110,
      NOC_CODE_END       = 3'b111
   } noc_code_e;

   typedef struct packed {
      logic       ctrl;
      noc_code_e  code;
      logic [1:0] rsvd;
      logic [2:0] size;
   } noc_frame_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_SRC,
      ST_ADDR,
      ST_DATA,
      ST_END
   } tx_state_e;

   localparam noc_frame_t NOC_IDLE_FRAME = '{ctrl: 1'b1, code: NOC_CODE_IDLE, rsvd: 2'b00, size: 3'b000};
   localparam noc_frame_t NOC_END_FRAME  = '{ctrl: 1'b1, code: NOC_CODE_END,  rsvd: 2'b00, size: 3'b000};

   // Non-linear AddrLen encoding: the top codes skip to 7, 8 and 12 bytes.
   function automatic logic [3:0] noc_size_bytes(input logic [2:0] size);
      logic [3:0] n;
      case (size)
         3'd0:    n = 4'd1;
         3'd1:    n = 4'd2;
         3'd2:    n = 4'd3;
         3'd3:    n = 4'd4;
         3'd4:    n = 4'd5;
         3'd5:    n = 4'd7;
         3'd6:    n = 4'd8;
         default: n = 4'd12;
      endcase
      return n;
   endfunction

   function automatic noc_frame_t noc_ctrl_frame(input noc_code_e code, input logic [2:0] size);
      noc_frame_t f;
      f.ctrl = 1'b1;
      f.code = code;
      f.rsvd = 2'b00;
      f.size = size;
      return f;
   endfunction

   function automatic noc_frame_t noc_data_frame(input logic [7:0] b);
      return noc_frame_t'({1'b0, b});
   endfunction

endpackage

// File: rtl/noc_rr_arb2.sv
// Two-way round-robin arbiter; combinational win while enabled, last winner registered.
// No backpressure of its own: requests are only considered when en is high.
module noc_rr_arb2
   import noc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic rd_req,
   input  logic wr_req,
   output logic rd_win,
   output logic wr_win
);

   // Reset to "write served last" so the first tie goes to the read side.
   logic last_wr;

   assign rd_win = en && rd_req && (!wr_req || last_wr);
   assign wr_win = en && wr_req && (!rd_req || !last_wr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr <= 1'b1;
      end else if (rd_win) begin
         last_wr <= 1'b0;
      end else if (wr_win) begin
         last_wr <= 1'b1;
      end
   end

endmodule

// File: rtl/noc_tx_scheduler.sv
// Serializes one read or write packet at a time onto the 9-bit NoC link; grant 1 cycle after request in IDLE.
// Link backpressure holds the current frame; a stalled write payload stalls the packet without idle fill.
module noc_tx_scheduler
   import noc_pkg::*;
#(
   parameter logic [7:0] SRC_ID = 8'h01,
   parameter int         ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [2:0]        rd_size,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   input  logic              wr_req,
   input  logic [2:0]        wr_size,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_grant,
   input  logic [7:0]        wr_data,
   input  logic              wr_data_valid,
   output logic              wr_data_ready,
   output logic [8:0]        link_data,
   output logic              link_valid,
   input  logic              link_ready,
   output logic              busy
);

   tx_state_e         state;
   noc_frame_t        frame_q;
   logic              frame_vld;
   logic              is_wr;
   logic [2:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        byte_cnt;
   logic              rd_win;
   logic              wr_win;
   logic              xfer;
   logic [2:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;

   noc_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (state == ST_IDLE),
      .rd_req (rd_req),
      .wr_req (wr_req),
      .rd_win (rd_win),
      .wr_win (wr_win)
   );

   assign sel_size = wr_win ? wr_size : rd_size;
   assign sel_addr = wr_win ? wr_addr : rd_addr;
   assign busy     = (state != ST_IDLE);
   assign xfer     = link_valid && link_ready;

   // Header frames come from a register; payload bytes pass straight through
   // so a valid byte can go out in the same cycle it is offered.
   always_comb begin
      link_valid    = frame_vld;
      link_data     = frame_q;
      wr_data_ready = 1'b0;
      if (state == ST_DATA) begin
         link_valid    = wr_data_valid;
         link_data     = {1'b0, wr_data};
         wr_data_ready = wr_data_valid && link_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         frame_q   <= NOC_IDLE_FRAME;
         frame_vld <= 1'b0;
         is_wr     <= 1'b0;
         size_q    <= 3'd0;
         addr_q    <= '0;
         byte_cnt  <= 4'd0;
         rd_grant  <= 1'b0;
         wr_grant  <= 1'b0;
      end else begin
         rd_grant <= 1'b0;
         wr_grant <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_win || wr_win) begin
                  rd_grant  <= rd_win;
                  wr_grant  <= wr_win;
                  is_wr     <= wr_win;
                  size_q    <= sel_size;
                  addr_q    <= sel_addr;
                  frame_q   <= noc_ctrl_frame(wr_win ? NOC_CODE_WRITE : NOC_CODE_READ, sel_size);
                  frame_vld <= 1'b1;
                  state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (xfer) begin
                  frame_q <= noc_data_frame(SRC_ID);
                  state   <= ST_SRC;
               end
            end
            ST_SRC: begin
               if (xfer) begin
                  frame_q <= noc_data_frame(8'(addr_q));
                  state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (xfer) begin
                  if (is_wr) begin
                     byte_cnt  <= noc_size_bytes(size_q) - 4'd1;
                     frame_vld <= 1'b0;
                     state     <= ST_DATA;
                  end else begin
                     frame_q <= NOC_END_FRAME;
                     state   <= ST_END;
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  if (byte_cnt == 4'd0) begin
                     frame_q   <= NOC_END_FRAME;
                     frame_vld <= 1'b1;
                     state     <= ST_END;
                  end else begin
                     byte_cnt <= byte_cnt - 4'd1;
                  end
               end
            end
            ST_END: begin
               if (xfer) begin
                  frame_q   <= NOC_IDLE_FRAME;
                  frame_vld <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               frame_q   <= NOC_IDLE_FRAME;
               frame_vld <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
